// File: rtl/divider_sequencer.sv
// Multi-cycle RV32M divider: runs ITERS_PER_CYCLE restoring-division steps per clock
// and applies the RISC-V signed fix-up, divide-by-zero and overflow results.
module divider_sequencer #(
    parameter int ITERS_PER_CYCLE = 4,
    parameter int TAG_W           = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [1:0]       i_op,
    input  logic [31:0]      i_dividend,
    input  logic [31:0]      i_divisor,
    input  logic [TAG_W-1:0] i_tag,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [31:0]      o_result,
    output logic [TAG_W-1:0] o_tag,
    output logic             o_busy
);
    localparam int STEPS = 32 / ITERS_PER_CYCLE;
    localparam int CNT_W = $clog2(STEPS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic              is_rem_r, is_rem_s;
    logic              neg_q_r, neg_q_s;
    logic              neg_r_r, neg_r_s;
    logic [TAG_W-1:0]  tag_r, tag_s;
    logic [31:0]       a_r, a_s, b_r, b_s;
    logic [31:0]       rem_r, rem_s, quo_r, quo_s;
    logic [31:0]       result_r, result_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;

    logic [31:0]       iter_a_s, iter_r_s, iter_q_s, shift_s;
    logic [31:0]       final_s, special_s, mag_a_s, mag_b_s;
    logic              op_signed_s, div_zero_s, overflow_s;

    // ITERS_PER_CYCLE unrolled shift/compare/subtract steps, MSB first
    always_comb begin
        iter_a_s = a_r;
        iter_r_s = rem_r;
        iter_q_s = quo_r;
        shift_s  = 32'd0;
        for (int i = 0; i < ITERS_PER_CYCLE; i++) begin
            shift_s = {iter_r_s[30:0], iter_a_s[31]};
            if (shift_s >= b_r) begin
                iter_r_s = shift_s - b_r;
                iter_q_s = {iter_q_s[30:0], 1'b1};
            end else begin
                iter_r_s = shift_s;
                iter_q_s = {iter_q_s[30:0], 1'b0};
            end
            iter_a_s = {iter_a_s[30:0], 1'b0};
        end
    end

    // Operand decode at accept time and the signed fix-up of the final step
    always_comb begin
        op_signed_s = i_op[1];
        div_zero_s  = (i_divisor == 32'd0);
        overflow_s  = op_signed_s && (i_dividend == 32'h8000_0000) && (i_divisor == 32'hFFFF_FFFF);
        mag_a_s     = (op_signed_s && i_dividend[31]) ? (32'd0 - i_dividend) : i_dividend;
        mag_b_s     = (op_signed_s && i_divisor[31]) ? (32'd0 - i_divisor) : i_divisor;
        if (div_zero_s) begin
            special_s = i_op[0] ? i_dividend : 32'hFFFF_FFFF;
        end else begin
            special_s = i_op[0] ? 32'd0 : 32'h8000_0000;
        end
        if (is_rem_r) begin
            final_s = neg_r_r ? (32'd0 - iter_r_s) : iter_r_s;
        end else begin
            final_s = neg_q_r ? (32'd0 - iter_q_s) : iter_q_s;
        end
    end

    // Next-state and datapath-next logic; flush always wins
    always_comb begin
        state_s  = state_r;
        is_rem_s = is_rem_r;
        neg_q_s  = neg_q_r;
        neg_r_s  = neg_r_r;
        tag_s    = tag_r;
        a_s      = a_r;
        b_s      = b_r;
        rem_s    = rem_r;
        quo_s    = quo_r;
        result_s = result_r;
        cnt_s    = cnt_r;
        case (state_r)
            IDLE: begin
                if (i_flush) begin
                    state_s = IDLE;
                end else if (i_valid) begin
                    is_rem_s = i_op[0];
                    neg_q_s  = op_signed_s && (i_dividend[31] ^ i_divisor[31]);
                    neg_r_s  = op_signed_s && i_dividend[31];
                    tag_s    = i_tag;
                    a_s      = mag_a_s;
                    b_s      = mag_b_s;
                    rem_s    = 32'd0;
                    quo_s    = 32'd0;
                    cnt_s    = CNT_W'(STEPS);
                    if (div_zero_s || overflow_s) begin
                        result_s = special_s;
                        state_s  = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (i_flush) begin
                    state_s = IDLE;
                end else begin
                    a_s   = iter_a_s;
                    rem_s = iter_r_s;
                    quo_s = iter_q_s;
                    cnt_s = cnt_r - CNT_W'(1);
                    if (cnt_r == CNT_W'(1)) begin
                        result_s = final_s;
                        state_s  = DONE;
                    end else begin
                        state_s = RUN;
                    end
                end
            end
            DONE: begin
                if (i_flush || i_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Datapath and result registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_rem_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            tag_r    <= '0;
            a_r      <= 32'd0;
            b_r      <= 32'd0;
            rem_r    <= 32'd0;
            quo_r    <= 32'd0;
            result_r <= 32'd0;
            cnt_r    <= '0;
        end else begin
            is_rem_r <= is_rem_s;
            neg_q_r  <= neg_q_s;
            neg_r_r  <= neg_r_s;
            tag_r    <= tag_s;
            a_r      <= a_s;
            b_r      <= b_s;
            rem_r    <= rem_s;
            quo_r    <= quo_s;
            result_r <= result_s;
            cnt_r    <= cnt_s;
        end
    end

    assign o_ready  = (state_r == IDLE);
    assign o_valid  = (state_r == DONE);
    assign o_busy   = (state_r != IDLE);
    assign o_result = result_r;
    assign o_tag    = tag_r;
endmodule
